// File: rtl/addr_read_responder.sv
// addr_read_responder: small word bank filled sequentially by a producer, then
// served to an address sequencer with a one-cycle acknowledge. Once every entry
// has been read at least once, the block pulses done and re-arms for a new fill.
module addr_read_responder #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              OE,
    input  logic [ADDR_W-1:0] add_i,
    output logic [DATA_W-1:0] data_o,
    output logic              OE_R,
    output logic              full_o,
    output logic              done_o,
    output logic              err_o,
    output logic              ovf_o
);

    // wr_ptr and rd_cnt must be able to hold DEPTH itself, not just DEPTH-1
    localparam int PTR_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_A  = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [0:0] {
        ST_FILL  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    state_e            state_q,   state_d;
    logic [PTR_W-1:0]  wr_ptr_q,  wr_ptr_d;
    logic [PTR_W-1:0]  rd_cnt_q,  rd_cnt_d;
    logic [DEPTH-1:0]  rd_seen_q, rd_seen_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DATA_W-1:0] data_q,    data_d;
    logic              oe_r_q,    oe_r_d;
    logic              full_q,    full_d;
    logic              done_q,    done_d;
    logic              err_q,     err_d;
    logic              ovf_q,     ovf_d;

    logic [IDX_W-1:0]  wr_idx_s;
    logic [IDX_W-1:0]  rd_idx_s;
    logic              addr_ok_s;

    // Index slices; rd_idx_s is only meaningful when addr_ok_s is set
    always_comb begin
        wr_idx_s  = wr_ptr_q[IDX_W-1:0];
        rd_idx_s  = add_i[IDX_W-1:0];
        addr_ok_s = ({1'b0, add_i} < DEPTH_A);
    end

    // Next-state, bank update and output computation; clr overrides everything
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_cnt_d  = rd_cnt_q;
        rd_seen_d = rd_seen_q;
        mem_d     = mem_q;
        data_d    = data_q;
        full_d    = full_q;
        oe_r_d    = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        ovf_d     = 1'b0;

        if (clr) begin
            // Abandon the pass; bank contents and last read data are kept
            state_d   = ST_FILL;
            wr_ptr_d  = '0;
            rd_cnt_d  = '0;
            rd_seen_d = '0;
            full_d    = 1'b0;
        end else begin
            case (state_q)
                ST_FILL: begin
                    if (wr_en) begin
                        mem_d[wr_idx_s] = wr_data;
                        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
                        if (wr_ptr_q == LAST_PTR) begin
                            state_d = ST_READY;
                            full_d  = 1'b1;
                        end else begin
                            state_d = ST_FILL;
                        end
                    end else begin
                        wr_ptr_d = wr_ptr_q;
                    end
                    // Reads are refused until the bank is complete
                    if (OE) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = 1'b0;
                    end
                end
                ST_READY: begin
                    // The bank is frozen while serving; writes are dropped
                    if (wr_en) begin
                        ovf_d = 1'b1;
                    end else begin
                        ovf_d = 1'b0;
                    end
                    if (OE && addr_ok_s) begin
                        data_d = mem_q[rd_idx_s];
                        oe_r_d = 1'b1;
                        if (!rd_seen_q[rd_idx_s]) begin
                            rd_seen_d[rd_idx_s] = 1'b1;
                            rd_cnt_d            = rd_cnt_q + PTR_W'(1);
                            if (rd_cnt_q == LAST_PTR) begin
                                // Last unseen entry read: finish and re-arm
                                done_d    = 1'b1;
                                full_d    = 1'b0;
                                state_d   = ST_FILL;
                                wr_ptr_d  = '0;
                                rd_cnt_d  = '0;
                                rd_seen_d = '0;
                            end else begin
                                done_d = 1'b0;
                            end
                        end else begin
                            rd_cnt_d = rd_cnt_q;
                        end
                    end else if (OE) begin
                        err_d = 1'b1;
                    end else begin
                        oe_r_d = 1'b0;
                    end
                end
                default: begin
                    state_d   = ST_FILL;
                    wr_ptr_d  = '0;
                    rd_cnt_d  = '0;
                    rd_seen_d = '0;
                    full_d    = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_FILL;
            wr_ptr_q  <= '0;
            rd_cnt_q  <= '0;
            rd_seen_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            data_q    <= '0;
            oe_r_q    <= 1'b0;
            full_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_cnt_q  <= rd_cnt_d;
            rd_seen_q <= rd_seen_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            data_q    <= data_d;
            oe_r_q    <= oe_r_d;
            full_q    <= full_d;
            done_q    <= done_d;
            err_q     <= err_d;
            ovf_q     <= ovf_d;
        end
    end

    assign data_o = data_q;
    assign OE_R   = oe_r_q;
    assign full_o = full_q;
    assign done_o = done_q;
    assign err_o  = err_q;
    assign ovf_o  = ovf_q;

endmodule

// File: doc/addr_read_responder.md
# addr_read_responder

Read-side responder for the address-sequencer interface. A producer first fills a small word bank sequentially. A sequencer then presents an address on `add_i` with a read strobe `OE`, and this block returns the addressed word with a one-cycle acknowledge `OE_R`. After every entry has been read once, the block signals completion and re-arms for the next fill. It sits between the data producer and the 3-bit address sequencer in the hardware test path.

## Interface
- `DATA_W`, 8: word width.
- `ADDR_W`, 3: width of `add_i`.
- `DEPTH`, 4: number of bank entries; must satisfy `DEPTH <= 2**ADDR_W`.
- `CLK`  in  1  single clock; all logic is on the rising edge.
- `RST_N`  in  1  reset, asynchronous and active-low.
- `clr`  in  1  synchronous clear; abandons the current fill or read pass.
- `wr_en`  in  1  write strobe for the fill side.
- `wr_data`  in  DATA_W  word to write.
- `OE`  in  1  read request strobe from the sequencer.
- `add_i`  in  ADDR_W  read address, sampled when `OE`=1.
- `data_o`  out  DATA_W  registered read data.
- `OE_R`  out  1  read acknowledge; one-cycle pulse, `data_o` valid.
- `full_o`  out  1  level; bank filled and serving reads.
- `done_o`  out  1  one-cycle pulse; all DEPTH entries have been read.
- `err_o`  out  1  one-cycle pulse; a rejected read.
- `ovf_o`  out  1  one-cycle pulse; a dropped write.

## Operation
- Internal state:
  - `mem[0..DEPTH-1]`
  - `wr_ptr` (0..DEPTH)
  - `rd_cnt` (0..DEPTH)
  - `rd_seen[DEPTH]` (bit per entry)
  - two-state FSM: FILL, READY
- Reset (`RST_N`=0, asynchronous):
  - state FILL; `wr_ptr`, `rd_cnt`, `rd_seen` = 0; `mem` = 0.
  - All outputs 0.
- FILL state:
  - `wr_en`=1: `mem[wr_ptr]` <= `wr_data`, and `wr_ptr` increments.
  - When that write is entry DEPTH-1: go to READY and set `full_o`=1 on the same edge.
  - `OE`=1 in FILL: no read; `err_o` pulses; `OE_R` stays 0.
- READY state:
  - `OE`=1 with `add_i` < DEPTH: `data_o` <= `mem[add_i]` and `OE_R` pulses.
    - If `rd_seen[add_i]`=0: set it and increment `rd_cnt`.
    - Re-reading an address already read is legal and returns data, but does not count.
  - `OE`=1 with `add_i` >= DEPTH: `err_o` pulses; `data_o` unchanged; `OE_R` stays 0.
  - On the accepted read that brings `rd_cnt` to DEPTH (same edge as `OE_R`):
    - `done_o` pulses.
    - `full_o` goes to 0.
    - `wr_ptr`, `rd_cnt`, `rd_seen` clear; FSM returns to FILL.
  - `wr_en`=1 in READY: write dropped, `ovf_o` pulses, `mem` unchanged. A simultaneous `OE` is still served normally.
- `clr`=1 (synchronous, highest priority):
  - FSM to FILL; `wr_ptr`, `rd_cnt`, `rd_seen` = 0; `full_o` = 0.
  - `mem` and `data_o` retained.
  - No pulse outputs that cycle; `OE` and `wr_en` ignored.
- `data_o` holds its last value between reads.
- Address arithmetic is unsigned. `wr_ptr` never wraps: it is cleared, never overflowed.

## Timing
- Read latency is 1 cycle. `OE` sampled at edge k gives `data_o`/`OE_R` valid after edge k, and `OE_R` falls after edge k+1 unless a new read is accepted.
- Back-to-back reads every cycle are supported; `OE_R` stays high continuously for consecutive accepted reads.
- The fill write at edge k is readable by an `OE` sampled at edge k+1 at the earliest.
- Pulse outputs (`done_o`, `err_o`, `ovf_o`) are registered and last exactly one cycle.
- Minimum full cycle: DEPTH fill cycles + DEPTH read cycles. The next fill write is accepted on the edge after `done_o`.
- `RST_N` asserted mid-pass clears everything immediately, without waiting for a clock edge.

## Test plan
- Reset, then fill 0x11, 0x22, 0x33, 0x44 on 4 consecutive cycles.
  - `full_o`=1 after the 4th edge.
  - Read addresses 0,1,2,3 back-to-back: `data_o` = 0x11, 0x22, 0x33, 0x44 with `OE_R` high for 4 cycles.
  - `done_o` pulses with the 4th read; `full_o`=0.
- After a fill, read addresses 2,2,0,1,3.
  - 5 `OE_R` pulses; address 2 returns 0x33 twice.
  - `done_o` fires only on the read of address 3.
- `OE` with `add_i`=5 in READY gives an `err_o` pulse, no `OE_R`, and `data_o` unchanged. `OE` during FILL gives `err_o`.
- `wr_en` with 0x99 while READY and `OE` `add_i`=1 in the same cycle:
  - `ovf_o` pulses and `OE_R` returns 0x22.
  - A later read of any address never returns 0x99.
- Fill 2 words, assert `clr`, then fill 0xA0..0xA3:
  - reads return 0xA0..0xA3;
  - `full_o` was 0 after `clr`.
- Drop `RST_N` asynchronously mid-read pass: all outputs go to 0 without a clock edge, and a subsequent read returns 0x00 only after a refill with 0x00.
